// File: rtl/run_scan_pkg.sv
// Shared types for the run-length scan controller and its bit-serial run detector.
// The detector history option is selected in run_scan_ctrl by RUN_SCAN_HISTORY_EN.
package run_scan_pkg;

    localparam int unsigned RUN_LEN = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } ctrl_state_e;

    typedef enum logic [3:0] {
        DetZ0,
        DetZ1,
        DetZ2,
        DetZ3,
        DetZ4,
        DetO1,
        DetO2,
        DetO3,
        DetO4
    } det_state_e;

    // Z4/O4 stand for "run of RUN_LEN or more" and absorb further identical bits.
    function automatic det_state_e det_next(input det_state_e s, input logic b);
        det_state_e n;
        n = b ? DetO1 : DetZ1;
        unique case (s)
            DetZ1:   if (!b) n = DetZ2;
            DetZ2:   if (!b) n = DetZ3;
            DetZ3:   if (!b) n = DetZ4;
            DetZ4:   if (!b) n = DetZ4;
            DetO1:   if (b)  n = DetO2;
            DetO2:   if (b)  n = DetO3;
            DetO3:   if (b)  n = DetO4;
            DetO4:   if (b)  n = DetO4;
            default: n = b ? DetO1 : DetZ1;
        endcase
        return n;
    endfunction

    function automatic logic det_flag(input det_state_e s);
        return (s == DetZ4) || (s == DetO4);
    endfunction

endpackage

// File: rtl/run_det.sv
// Nine-state Moore run detector: flags a run of RUN_LEN or more identical bits.
// flag_next is the flag the detector will show after absorbing bit_in.
module run_det
    import run_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic flag_next,
    output logic flag
);

    det_state_e state;
    det_state_e state_next;

    assign state_next = det_next(state, bit_in);
    assign flag_next  = det_flag(state_next);
    assign flag       = det_flag(state);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= DetZ0;
        end else if (clr) begin
            state <= DetZ0;
        end else if (en) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/run_scan_ctrl.sv
// Word-to-bit sequencer around run_det; counts flagged bit positions per word (saturating).
// Define RUN_SCAN_HISTORY_EN to let detector runs continue across word boundaries.
module run_scan_ctrl
    import run_scan_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_hits,
    output logic              busy
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    ctrl_state_e       state;
    logic [WORD_W-1:0] sreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  hits;
    logic              word_start;
    logic              det_clr;
    logic              det_en;
    logic              det_flag_next;
    logic              unused_det_flag;

    assign word_start = (state == StIdle) && in_valid;
    assign det_en     = (state == StShift);

`ifdef RUN_SCAN_HISTORY_EN
    assign det_clr = 1'b0;
`else
    assign det_clr = word_start;
`endif

    run_det u_run_det (
        .clk       (clk),
        .reset     (reset),
        .clr       (det_clr),
        .en        (det_en),
        .bit_in    (sreg[0]),
        .flag_next (det_flag_next),
        .flag      (unused_det_flag)
    );

    assign out_hits = hits;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sreg      <= '0;
            bit_idx   <= '0;
            hits      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (word_start) begin
                        state    <= StShift;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        sreg     <= in_data;
                        bit_idx  <= '0;
                        hits     <= '0;
                    end
                end
                StShift: begin
                    sreg    <= sreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                    if (det_flag_next && (hits != CNT_MAX)) begin
                        hits <= hits + 1'b1;
                    end
                    if (bit_idx == LAST_IDX) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_scan_ctrl.sv
// Directed bench for run_scan_ctrl (WORD_W=8) plus a CNT_W=2 instance for saturation.
// Expected hit counts depend on whether RUN_SCAN_HISTORY_EN is defined.
module tb_run_scan_ctrl;

`ifdef RUN_SCAN_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_hits;
    logic       busy;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [7:0] s_in_data;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [1:0] s_out_hits;
    logic       s_busy;

    int n_checks;
    int n_fail;

    run_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hits  (out_hits),
        .busy      (busy)
    );

    run_scan_ctrl #(.WORD_W(8), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_hits  (s_out_hits),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a word, feed its eight bits, and check the result sits in DONE.
    task automatic run_word(input string tag, input logic [7:0] data, input logic [3:0] exp);
        in_valid = 1'b1;
        in_data  = data;
        step();
        in_valid = 1'b0;
        in_data  = ~data;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
        repeat (7) step();
        check({tag, " early valid"}, 32'(out_valid), 32'd0);
        step();
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " hits"}, 32'(out_hits), 32'(exp));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " done valid"}, 32'(out_valid), 32'd0);
        check({tag, " done ready"}, 32'(in_ready), 32'd1);
        check({tag, " done busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = 8'h00;
        s_out_ready = 1'b0;
        step();
        step();
        reset = 1'b1;

        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst hits", 32'(out_hits), 32'd0);

        // Saturation: 0x00 has five flagged bits, CNT_W=2 holds at 3.
        s_in_valid = 1'b1;
        s_in_data  = 8'h00;
        step();
        s_in_valid = 1'b0;
        repeat (8) step();
        check("sat valid", 32'(s_out_valid), 32'd1);
        check("sat hits", 32'(s_out_hits), 32'd3);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        check("sat done", 32'(s_out_valid), 32'd0);

        run_word("w00", 8'h00, 4'd5);
        consume("w00");
        run_word("wff", 8'hFF, 4'd5);
        consume("wff");
        run_word("w0f", 8'h0F, HIST ? 4'd5 : 4'd2);
        consume("w0f");

        // Back-pressure on 0x55 with a new word pending on the input.
        run_word("w55", 8'h55, 4'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp valid", 32'(out_valid), 32'd1);
            check("bp hits", 32'(out_hits), 32'd0);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp consumed", 32'(out_valid), 32'd0);
        check("bp not taken", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp taken busy", 32'(busy), 32'd1);
        check("bp taken ready", 32'(in_ready), 32'd0);
        repeat (7) step();
        check("waa early", 32'(out_valid), 32'd0);
        step();
        check("waa valid", 32'(out_valid), 32'd1);
        check("waa hits", 32'(out_hits), 32'd0);
        consume("waa");

        run_word("w00a", 8'h00, 4'd5);
        consume("w00a");
        run_word("w00b", 8'h00, HIST ? 4'd8 : 4'd5);
        consume("w00b");
        run_word("wf0", 8'hF0, HIST ? 4'd5 : 4'd2);
        consume("wf0");

        // Reset in the middle of 0xFF; the detector must come back at Z0.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("mid busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid in_ready", 32'(in_ready), 32'd1);
        check("mid busy", 32'(busy), 32'd0);
        check("mid out_valid", 32'(out_valid), 32'd0);
        check("mid hits", 32'(out_hits), 32'd0);
        run_word("post", 8'hFF, 4'd5);
        consume("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
